// File: rtl/bank_isu_sched_if.sv
// Channel request bus and ISU request port of the bank ISU front-end scheduler.
// The scheduler uses the slave view. The channel queues and the ISU together use the master view.
interface bank_isu_sched_if;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_ready;
  logic [7:0]  ch_opcode;
  logic [27:0] ch_set_way_offset;
  logic [31:0] ch_wbuffer_id;

  logic        isu_valid;
  logic        isu_ready;
  logic [1:0]  isu_ch_id;
  logic [1:0]  isu_opcode;
  logic [6:0]  isu_set_way_offset;
  logic [7:0]  isu_wbuffer_id;

  modport master (
    output ch_valid, ch_opcode, ch_set_way_offset, ch_wbuffer_id, isu_ready,
    input  ch_ready, isu_valid, isu_ch_id, isu_opcode, isu_set_way_offset, isu_wbuffer_id
  );

  modport slave (
    input  ch_valid, ch_opcode, ch_set_way_offset, ch_wbuffer_id, isu_ready,
    output ch_ready, isu_valid, isu_ch_id, isu_opcode, isu_set_way_offset, isu_wbuffer_id
  );
endinterface

// File: rtl/bank_isu_sched.sv
// Round-robin arbiter of four channel streams into the ISU request port. It holds back any
// request whose set/way has a linefill in flight in the 8x8 scoreboard.
module bank_isu_sched #(
  parameter int NCH  = 4,
  parameter int NSET = 8,
  parameter int NWAY = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  bank_isu_sched_if.slave      bus,
  input  logic                 lf_alloc_valid_i,
  input  logic [2:0]           lf_alloc_set_i,
  input  logic [2:0]           lf_alloc_way_i,
  input  logic                 lf_done_valid_i,
  input  logic [2:0]           lf_done_set_i,
  input  logic [2:0]           lf_done_way_i,
  output logic [NSET*NWAY-1:0] inflight_o,
  output logic                 lf_err_o
);
  localparam int NLINE = NSET * NWAY;

  logic [NLINE-1:0] sb_q, sb_next, alloc_mask, done_mask;
  logic             err_q, err_next;
  logic [5:0]       alloc_idx, done_idx;

  logic [1:0]       ptr_q;
  logic [NCH-1:0]   elig;
  logic [1:0]       winner;
  logic             found, load, grant;

  logic             valid_q;
  logic [1:0]       ch_id_q, opcode_q;
  logic [6:0]       swo_q;
  logic [7:0]       wbid_q;

  assign alloc_idx = {lf_alloc_set_i, lf_alloc_way_i};
  assign done_idx  = {lf_done_set_i, lf_done_way_i};

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    alloc_mask = '0;
    done_mask  = '0;
    if (lf_alloc_valid_i) alloc_mask[alloc_idx] = 1'b1;
    if (lf_done_valid_i)  done_mask[done_idx]   = 1'b1;
    // Alloc wins over a same-cycle done because it is ORed in last.
    sb_next  = (sb_q & ~done_mask) | alloc_mask;
    err_next = (lf_alloc_valid_i & sb_q[alloc_idx]) |
               (lf_done_valid_i & ~sb_q[done_idx]);
  end

  // Hazard check uses the registered scoreboard and ignores the offset bit.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++)
      elig[i] = bus.ch_valid[i] & ~sb_q[bus.ch_set_way_offset[7*i+1 +: 6]];
  end

  always_comb begin
    logic [1:0] cand;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && elig[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign load         = ~valid_q | bus.isu_ready;
  // rst_ni gating keeps ch_ready low during reset, because the arbiter state is zero then.
  assign grant        = load & found & rst_ni;
  assign bus.ch_ready = grant ? (4'b0001 << winner) : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q     <= '0;
      err_q    <= 1'b0;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      ch_id_q  <= '0;
      opcode_q <= '0;
      swo_q    <= '0;
      wbid_q   <= '0;
    end else begin
      sb_q  <= sb_next;
      err_q <= err_next;
      if (load) begin
        if (found) begin
          valid_q  <= 1'b1;
          ch_id_q  <= winner;
          opcode_q <= bus.ch_opcode[2*winner +: 2];
          swo_q    <= bus.ch_set_way_offset[7*winner +: 7];
          wbid_q   <= bus.ch_wbuffer_id[8*winner +: 8];
          ptr_q    <= winner + 2'd1;
        end else begin
          valid_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.isu_valid          = valid_q;
  assign bus.isu_ch_id          = ch_id_q;
  assign bus.isu_opcode         = opcode_q;
  assign bus.isu_set_way_offset = swo_q;
  assign bus.isu_wbuffer_id     = wbid_q;
  assign inflight_o             = sb_q;
  assign lf_err_o               = err_q;
endmodule
